// File: rtl/cifra_arbitro.sv
`default_nettype none
// ============================================================================
//  Module      : cifra_arbitro
//  Description : Two-requester arbiter that shares one BCD cipher unit.
//                Grants one digit at a time (alternating under contention),
//                strobes the cipher, waits LAT cycles, captures the code and
//                acknowledges the granted requester.
//  Revision    : 1.0  initial release
// ============================================================================
module cifra_arbitro #(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] dig0,
    input  logic       req1,
    input  logic [3:0] dig1,
    output logic       ack0,
    output logic       ack1,
    output logic [4:0] res,
    output logic       err,
    output logic [3:0] cif_e,
    output logic       cif_ready,
    input  logic [4:0] cif_s,
    output logic       busy,
    output logic [7:0] count
);

    localparam logic [3:0] LAT_LOAD = 4'(LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] wait_cnt;
    logic       gnt_idx;     // requester currently being served
    logic       last_srv;    // requester served most recently
    logic       grant_go;
    logic       grant_sel;

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and arbitration decision
    always_comb begin
        state_nx  = state;
        grant_go  = 1'b0;
        grant_sel = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant_go  = 1'b1;
                    grant_sel = ~last_srv;   // the one not served last wins
                end else if (req0) begin
                    grant_go  = 1'b1;
                    grant_sel = 1'b0;
                end else if (req1) begin
                    grant_go  = 1'b1;
                    grant_sel = 1'b1;
                end
                if (grant_go) state_nx = ISSUE;
            end
            ISSUE:   state_nx = WAIT;
            WAIT:    if (wait_cnt == 4'd1) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: digit latch, wait counter, result capture, served counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cif_e    <= 4'd0;
            gnt_idx  <= 1'b0;
            last_srv <= 1'b1;        // so requester 0 wins the first tie
            wait_cnt <= 4'd0;
            res      <= 5'd0;
            err      <= 1'b0;
            count    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_go) begin
                        cif_e   <= grant_sel ? dig1 : dig0;
                        gnt_idx <= grant_sel;
                    end
                end
                ISSUE: wait_cnt <= LAT_LOAD;
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        res <= cif_s;
                        err <= cif_e[3] & (cif_e[2] | cif_e[1]);
                    end
                end
                RESP: begin
                    last_srv <= gnt_idx;
                    if (!err) count <= count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode directly from the state register, so reset clears them
    assign busy      = (state != IDLE);
    assign cif_ready = (state == ISSUE);
    assign ack0      = (state == RESP) && !gnt_idx;
    assign ack1      = (state == RESP) &&  gnt_idx;

endmodule
`default_nettype wire

// File: tb/tb_cifra_arbitro.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cifra_arbitro
//  Description : Directed, table-driven bench for cifra_arbitro (LAT=1 and
//                LAT=4 instances) with a lookup-table cipher stub.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cifra_arbitro;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    // LAT=1 instance
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] dig0 = 4'd0, dig1 = 4'd0;
    logic       ack0, ack1, err, cif_ready, busy;
    logic [4:0] res, cif_s;
    logic [3:0] cif_e;
    logic [7:0] count;

    // LAT=4 instance
    logic       r4_req0 = 1'b0, r4_req1 = 1'b0;
    logic [3:0] r4_dig0 = 4'd0, r4_dig1 = 4'd0;
    logic       ack0_4, ack1_4, err_4, cif_ready_4, busy_4;
    logic [4:0] res_4, cif_s_4;
    logic [3:0] cif_e_4;
    logic [7:0] count_4;

    int checks = 0;
    int errors = 0;

    // Cipher stub: known codes for 0, 3, 12; a fixed table for the rest
    function automatic logic [4:0] cipher(input logic [3:0] d);
        case (d)
            4'd0:    return 5'b10000;
            4'd3:    return 5'b11110;
            4'd12:   return 5'b01110;
            default: return {1'b0, d} ^ 5'b10101;
        endcase
    endfunction

    assign cif_s   = cipher(cif_e);
    assign cif_s_4 = cipher(cif_e_4);

    always #5 clk = ~clk;

    cifra_arbitro #(.LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .dig0(dig0), .req1(req1), .dig1(dig1),
        .ack0(ack0), .ack1(ack1), .res(res), .err(err),
        .cif_e(cif_e), .cif_ready(cif_ready), .cif_s(cif_s),
        .busy(busy), .count(count)
    );

    cifra_arbitro #(.LAT(4)) dut4 (
        .clk(clk), .reset(reset),
        .req0(r4_req0), .dig0(r4_dig0), .req1(r4_req1), .dig1(r4_dig1),
        .ack0(ack0_4), .ack1(ack1_4), .res(res_4), .err(err_4),
        .cif_e(cif_e_4), .cif_ready(cif_ready_4), .cif_s(cif_s_4),
        .busy(busy_4), .count(count_4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       r0, r1;
        logic [3:0] d0, d1;
        logic       a0, a1;
        logic [4:0] res;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // Single transactions from reset (pointer starts at 1)
        vecs[0] = '{1'b1, 1'b0, 4'd3,  4'd0,  1'b1, 1'b0, 5'b11110, 1'b0, 8'd1};
        vecs[1] = '{1'b0, 1'b1, 4'd0,  4'd12, 1'b0, 1'b1, 5'b01110, 1'b1, 8'd1};
        vecs[2] = '{1'b1, 1'b1, 4'd0,  4'd3,  1'b1, 1'b0, 5'b10000, 1'b0, 8'd2};
        vecs[3] = '{1'b1, 1'b1, 4'd3,  4'd0,  1'b0, 1'b1, 5'b10000, 1'b0, 8'd3};
        vecs[4] = '{1'b1, 1'b0, 4'd9,  4'd0,  1'b1, 1'b0, 5'b11100, 1'b0, 8'd4};
        vecs[5] = '{1'b0, 1'b1, 4'd0,  4'd10, 1'b0, 1'b1, 5'b11111, 1'b1, 8'd4};
        vecs[6] = '{1'b1, 1'b0, 4'd15, 4'd0,  1'b1, 1'b0, 5'b11010, 1'b1, 8'd4};

        // ---- reset state
        do_reset();
        chk("rst_outs", {ack0, ack1, cif_ready, busy, err, res, cif_e, count}, 32'd0);
        chk("rst_outs4", {ack0_4, ack1_4, cif_ready_4, busy_4, err_4, res_4, cif_e_4, count_4}, 32'd0);
        tick();
        chk("idle_stays", {busy, cif_ready, ack0, ack1}, 32'd0);

        // ---- table-driven single transactions (LAT=1)
        for (int i = 0; i < 7; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            dig0 = vecs[i].d0; dig1 = vecs[i].d1;
            tick();                                   // cycle 1: ISSUE
            chk($sformatf("v%0d_issue", i), {cif_ready, busy}, 32'b11);
            req0 = 1'b0; req1 = 1'b0;                 // dropped after grant
            dig0 = 4'd7; dig1 = 4'd7;                 // must not affect cif_e
            tick();                                   // cycle 2: WAIT
            chk($sformatf("v%0d_wait", i), {cif_ready, busy, ack0, ack1}, 32'b0100);
            tick();                                   // cycle 3: RESP
            chk($sformatf("v%0d_resp", i), {ack0, ack1, res, err},
                {vecs[i].a0, vecs[i].a1, vecs[i].res, vecs[i].err});
            tick();                                   // cycle 4: IDLE
            chk($sformatf("v%0d_count", i), {busy, count}, {1'b0, vecs[i].cnt});
        end

        // ---- continuous dual requests alternate, LAT+3 spacing
        do_reset();
        begin
            int n = 0;
            int both = 0;
            req0 = 1'b1; req1 = 1'b1; dig0 = 4'd0; dig1 = 4'd3;
            for (int c = 1; c <= 17 && n < 4; c++) begin
                tick();
                if (ack0 && ack1) both++;
                if (ack0 || ack1) begin
                    chk($sformatf("alt%0d", n), {c[7:0], ack0, ack1, res},
                        {8'(3 + 4 * n), (n % 2 == 0), (n % 2 == 1),
                         (n % 2 == 0) ? 5'b10000 : 5'b11110});
                    n++;
                end
            end
            chk("alt_nacks", n, 4);
            chk("alt_noboth", both, 0);
            req0 = 1'b0; req1 = 1'b0;
            tick(); tick(); tick(); tick();
        end

        // ---- LAT=4: four WAIT cycles, ack at cycle 6, cif_e stable
        do_reset();
        begin
            int waits = 0;
            int ackc = -1;
            int unstable = 0;
            r4_req0 = 1'b1; r4_dig0 = 4'd3;
            tick();
            chk("l4_issue", {cif_ready_4, busy_4}, 32'b11);
            r4_req0 = 1'b0;
            for (int c = 2; c <= 20 && ackc < 0; c++) begin
                r4_dig0 = r4_dig0 ^ 4'hF;
                tick();
                if (ack0_4) ackc = c;
                else if (busy_4 && !cif_ready_4) waits++;
                if (cif_e_4 !== 4'd3) unstable++;
            end
            chk("l4_ack_cycle", ackc, 6);
            chk("l4_waits", waits, 4);
            chk("l4_cif_e_stable", unstable, 0);
            chk("l4_res", {res_4, err_4}, {5'b11110, 1'b0});
            r4_dig0 = 4'd0;
            tick();
            chk("l4_count", count_4, 8'd1);
        end

        // ---- reset during WAIT aborts, then req0 wins the tie
        do_reset();
        begin
            int ackc = -1;
            req0 = 1'b1; dig0 = 4'd3;
            tick();                 // ISSUE
            req0 = 1'b0;
            tick();                 // WAIT
            chk("abort_in_wait", {busy, cif_ready}, 32'b10);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("abort_outs", {ack0, ack1, cif_ready, busy, err, res, cif_e, count}, 32'd0);
            req0 = 1'b1; req1 = 1'b1; dig0 = 4'd0; dig1 = 4'd3;
            for (int c = 1; c <= 10 && ackc < 0; c++) begin
                tick();
                if (ack0 || ack1) begin
                    ackc = c;
                    chk("abort_first_grant", {ack0, ack1, res}, {2'b10, 5'b10000});
                end
            end
            chk("abort_ack_cycle", ackc, 3);
            req0 = 1'b0; req1 = 1'b0;
            tick(); tick(); tick(); tick();
        end

        // ---- 256 valid transactions wrap count to 0
        do_reset();
        begin
            int n = 0;
            req0 = 1'b1; dig0 = 4'd3;
            for (int c = 0; c < 256 * 4 + 50 && n < 256; c++) begin
                tick();
                if (ack0) begin
                    n++;
                    tick();
                    if (n == 255) chk("wrap_255", count, 8'd255);
                    if (n == 256) chk("wrap_0", count, 8'd0);
                end
            end
            chk("wrap_nacks", n, 256);
            req0 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
